// File: rtl/y86_seq_ctrl.sv
// ============================================================================
// y86_seq_ctrl : multi-cycle stage sequencer for the Y86-64 SEQ datapath
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module y86_seq_ctrl #(
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        run_i,
  input  logic [3:0]  icode_i,
  input  logic        cnd_i,
  input  logic        instruct_err_i,
  input  logic        mem_err_i,
  input  logic        mem_ready_i,
  input  logic [63:0] valp_i,
  input  logic [63:0] valc_i,
  input  logic [63:0] valm_i,
  output logic [63:0] pc_o,
  output logic        fetch_en_o,
  output logic        decode_en_o,
  output logic        exec_en_o,
  output logic        mem_en_o,
  output logic        wb_en_o,
  output logic [2:0]  stat_o,
  output logic        halted_o,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] instr_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Wait counter holds (memory cycles elapsed - 1), so the last allowed cycle is MEM_TIMEOUT-1.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [2:0]  stat_q, stat_d;
  logic [3:0]  icode_q, icode_d;
  logic        cnd_q, cnd_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] instr_q, instr_d;

  logic        exec_to_mem;
  logic        exec_to_wb;
  logic        mem_to_wb;
  logic [63:0] new_pc;

  always_comb begin
    exec_to_mem = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    exec_to_wb  = icode_q inside {4'h2, 4'h3, 4'h5, 4'h6, 4'hA, 4'hB};
    mem_to_wb   = icode_q inside {4'h5, 4'h9, 4'hA, 4'hB};
  end

  always_comb begin
    new_pc = valp_i;
    if (icode_q == 4'h8) begin
      new_pc = valc_i;
    end else if (icode_q == 4'h9) begin
      new_pc = valm_i;
    end else if ((icode_q == 4'h7) && cnd_q) begin
      new_pc = valc_i;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    icode_d = icode_q;
    cnd_d   = cnd_q;
    wait_d  = wait_q;
    cycle_d = cycle_q;
    instr_d = instr_q;

    if ((state_q != S_IDLE) && (state_q != S_HALT)) begin
      cycle_d = cycle_q + 32'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (run_i) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        icode_d = icode_i;
        // Fault priority: invalid instruction, then imem address fault, then halt.
        if (instruct_err_i) begin
          stat_d  = STAT_INS;
          state_d = S_HALT;
        end else if (mem_err_i) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else if (icode_i == 4'h0) begin
          stat_d  = STAT_HLT;
          state_d = S_HALT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        cnd_d  = cnd_i;
        wait_d = 8'd0;
        if (exec_to_mem) begin
          state_d = S_MEMORY;
        end else if (exec_to_wb) begin
          state_d = S_WRITEBACK;
        end else begin
          state_d = S_PCUPD;
        end
      end
      S_MEMORY: begin
        if (mem_err_i) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else if (mem_ready_i) begin
          state_d = mem_to_wb ? S_WRITEBACK : S_PCUPD;
        end else if (wait_q == WAIT_LAST) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WRITEBACK: begin
        state_d = S_PCUPD;
      end
      S_PCUPD: begin
        pc_d    = new_pc;
        instr_d = instr_q + 32'd1;
        state_d = run_i ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      stat_q  <= STAT_AOK;
      icode_q <= 4'h0;
      cnd_q   <= 1'b0;
      wait_q  <= 8'd0;
      cycle_q <= 32'd0;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      icode_q <= icode_d;
      cnd_q   <= cnd_d;
      wait_q  <= wait_d;
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  assign pc_o        = pc_q;
  assign fetch_en_o  = (state_q == S_FETCH);
  assign decode_en_o = (state_q == S_DECODE);
  assign exec_en_o   = (state_q == S_EXECUTE);
  assign mem_en_o    = (state_q == S_MEMORY);
  assign wb_en_o     = (state_q == S_WRITEBACK);
  assign stat_o      = stat_q;
  assign halted_o    = (state_q == S_HALT);
  assign cycle_cnt_o = cycle_q;
  assign instr_cnt_o = instr_q;

endmodule

`default_nettype wire

// File: tb/tb_y86_seq_ctrl.sv
// ============================================================================
// tb_y86_seq_ctrl : table-driven, per-cycle scoreboard bench for y86_seq_ctrl
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_y86_seq_ctrl;

  localparam logic [63:0] RST_PC = 64'd66;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        run_i = 1'b0;
  logic [3:0]  icode_i = 4'h0;
  logic        cnd_i = 1'b0;
  logic        instruct_err_i = 1'b0;
  logic        mem_err_i = 1'b0;
  logic        mem_ready_i = 1'b0;
  logic [63:0] valp_i = 64'd0;
  logic [63:0] valc_i = 64'd0;
  logic [63:0] valm_i = 64'd0;
  logic [63:0] pc_o;
  logic        fetch_en_o, decode_en_o, exec_en_o, mem_en_o, wb_en_o;
  logic [2:0]  stat_o;
  logic        halted_o;
  logic [31:0] cycle_cnt_o, instr_cnt_o;

  always #5 clk_i = ~clk_i;

  y86_seq_ctrl #(
    .RESET_PC    (RST_PC),
    .MEM_TIMEOUT (3)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .run_i          (run_i),
    .icode_i        (icode_i),
    .cnd_i          (cnd_i),
    .instruct_err_i (instruct_err_i),
    .mem_err_i      (mem_err_i),
    .mem_ready_i    (mem_ready_i),
    .valp_i         (valp_i),
    .valc_i         (valc_i),
    .valm_i         (valm_i),
    .pc_o           (pc_o),
    .fetch_en_o     (fetch_en_o),
    .decode_en_o    (decode_en_o),
    .exec_en_o      (exec_en_o),
    .mem_en_o       (mem_en_o),
    .wb_en_o        (wb_en_o),
    .stat_o         (stat_o),
    .halted_o       (halted_o),
    .cycle_cnt_o    (cycle_cnt_o),
    .instr_cnt_o    (instr_cnt_o)
  );

  // seq letters: F D E M W = stages, U = PC update (run=1), u = PC update (run=0),
  // H = halted, I = idle with run=1, Z = idle with run=0
  typedef struct {
    bit          pre_reset;
    logic [3:0]  icode;
    bit          ierr;
    bit          ferr;
    bit          merr;
    bit          cnd;
    int          rdy_at;
    logic [63:0] valp;
    logic [63:0] valc;
    logic [63:0] valm;
    string       seq;
    logic [63:0] exp_pc;
    logic [2:0]  exp_stat;
    bit          exp_halt;
  } vec_t;

  vec_t        vecs[$];
  logic [5:0]  exp_q[$];
  logic [5:0]  e_pop;
  int          n_chk = 0;
  int          n_pass = 0;
  int unsigned m_cyc = 0;
  int unsigned m_instr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic add_vec(input bit pr, input logic [3:0] ic, input bit ie, input bit fe,
                         input bit me, input bit cd, input int ra, input logic [63:0] vp,
                         input logic [63:0] vc, input logic [63:0] vm, input string sq,
                         input logic [63:0] epc, input logic [2:0] est, input bit eh);
    vec_t v;
    v.pre_reset = pr; v.icode = ic; v.ierr = ie; v.ferr = fe; v.merr = me; v.cnd = cd;
    v.rdy_at = ra; v.valp = vp; v.valc = vc; v.valm = vm; v.seq = sq;
    v.exp_pc = epc; v.exp_stat = est; v.exp_halt = eh;
    vecs.push_back(v);
  endtask

  function automatic logic [5:0] stage_en(input byte c);
    case (c)
      "F":     return 6'b010000;
      "D":     return 6'b001000;
      "E":     return 6'b000100;
      "M":     return 6'b000010;
      "W":     return 6'b000001;
      "H":     return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction

  always @(negedge clk_i) begin
    if (exp_q.size() != 0) begin
      e_pop = exp_q.pop_front();
      chk("stage_en", {58'd0, halted_o, fetch_en_o, decode_en_o, exec_en_o, mem_en_o, wb_en_o},
          {58'd0, e_pop});
    end
  end

  task automatic step(input int vi, input byte c, inout int mc);
    run_i          = !(c == "u" || c == "Z");
    icode_i        = vecs[vi].icode;
    cnd_i          = vecs[vi].cnd;
    valp_i         = vecs[vi].valp;
    valc_i         = vecs[vi].valc;
    valm_i         = vecs[vi].valm;
    instruct_err_i = 1'b0;
    mem_err_i      = 1'b0;
    mem_ready_i    = 1'b0;
    if (c == "F") begin
      instruct_err_i = vecs[vi].ierr;
      mem_err_i      = vecs[vi].ferr;
    end
    if (c == "M") begin
      mc++;
      mem_ready_i = (mc == vecs[vi].rdy_at);
      mem_err_i   = vecs[vi].merr && (mc == vecs[vi].rdy_at);
    end
    if (c == "H") begin
      mem_ready_i    = 1'b1;
      instruct_err_i = 1'b1;
    end
    if (c == "F" || c == "D" || c == "E" || c == "M" || c == "W" || c == "U" || c == "u")
      m_cyc++;
    if (c == "U" || c == "u") m_instr++;
    exp_q.push_back(stage_en(c));
    @(posedge clk_i); #1;
  endtask

  task automatic run_vec(input int vi);
    int mc = 0;
    for (int k = 0; k < vecs[vi].seq.len(); k++) step(vi, vecs[vi].seq[k], mc);
    chk($sformatf("v%0d_pc", vi), pc_o, vecs[vi].exp_pc);
    chk($sformatf("v%0d_stat", vi), {61'd0, stat_o}, {61'd0, vecs[vi].exp_stat});
    chk($sformatf("v%0d_halted", vi), {63'd0, halted_o}, {63'd0, vecs[vi].exp_halt});
    chk($sformatf("v%0d_instr_cnt", vi), {32'd0, instr_cnt_o}, {32'd0, m_instr});
    chk($sformatf("v%0d_cycle_cnt", vi), {32'd0, cycle_cnt_o}, {32'd0, m_cyc});
  endtask

  // Asynchronous reset: values are checked before any clock edge, then one IDLE cycle with run=1.
  task automatic do_reset();
    reset_i        = 1'b1;
    run_i          = 1'b0;
    instruct_err_i = 1'b0;
    mem_err_i      = 1'b0;
    mem_ready_i    = 1'b0;
    #2;
    chk("rst_pc", pc_o, RST_PC);
    chk("rst_stat", {61'd0, stat_o}, 64'd1);
    chk("rst_halted", {63'd0, halted_o}, 64'd0);
    chk("rst_en", {59'd0, fetch_en_o, decode_en_o, exec_en_o, mem_en_o, wb_en_o}, 64'd0);
    chk("rst_cycle_cnt", {32'd0, cycle_cnt_o}, 64'd0);
    chk("rst_instr_cnt", {32'd0, instr_cnt_o}, 64'd0);
    m_cyc   = 0;
    m_instr = 0;
    @(negedge clk_i);
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    run_i = 1'b1;
    exp_q.push_back(6'b000000);
    @(posedge clk_i); #1;
  endtask

  initial begin
    int mc;
    //      rst ic   ie fe me cd rdy valP  valC  valM  seq        expPC stat halt
    add_vec(1, 4'h3, 0, 0, 0, 0, 0,  76,   0,    0,    "FDEWU",   76,   1,   0); // 0 irmovq
    add_vec(0, 4'h4, 0, 0, 0, 0, 3,  100,  0,    0,    "FDEMMMU", 100,  1,   0); // 1 rmmovq, ready at limit
    add_vec(0, 4'h7, 0, 0, 0, 1, 0,  91,   34,   0,    "FDEU",    34,   1,   0); // 2 jXX taken
    add_vec(0, 4'h7, 0, 0, 0, 0, 0,  91,   34,   0,    "FDEU",    91,   1,   0); // 3 jXX not taken
    add_vec(0, 4'h5, 0, 0, 0, 0, 1,  101,  0,    0,    "FDEMWU",  101,  1,   0); // 4 mrmovq
    add_vec(0, 4'h8, 0, 0, 0, 0, 2,  111,  200,  0,    "FDEMMU",  200,  1,   0); // 5 call
    add_vec(0, 4'h9, 0, 0, 0, 0, 1,  210,  0,    300,  "FDEMWU",  300,  1,   0); // 6 ret
    add_vec(0, 4'hB, 0, 0, 0, 0, 1,  310,  0,    0,    "FDEMWU",  310,  1,   0); // 7 popq
    add_vec(0, 4'hA, 0, 0, 0, 0, 1,  320,  0,    0,    "FDEMWU",  320,  1,   0); // 8 pushq
    add_vec(0, 4'h2, 0, 0, 0, 0, 0,  322,  0,    0,    "FDEWU",   322,  1,   0); // 9 rrmovq
    add_vec(0, 4'h6, 0, 0, 0, 0, 0,  324,  0,    0,    "FDEWU",   324,  1,   0); // 10 OPq
    add_vec(0, 4'h1, 0, 0, 0, 0, 0,  325,  0,    0,    "FDEuZI",  325,  1,   0); // 11 nop, pause
    add_vec(0, 4'h7, 0, 0, 0, 1, 0,  335,  0,    0,    "FDEU",    0,    1,   0); // 12 jmp to 0
    add_vec(0, 4'h0, 0, 0, 0, 0, 0,  9,    9,    9,    "F",       0,    2,   1); // 13 halt at PC 0
    add_vec(0, 4'h3, 0, 0, 0, 1, 0,  999,  888,  777,  "HHH",     0,    2,   1); // 14 halt is sticky
    add_vec(1, 4'h3, 1, 1, 0, 0, 0,  76,   0,    0,    "F",       66,   4,   1); // 15 INS beats ADR
    add_vec(1, 4'h6, 0, 1, 0, 0, 0,  76,   0,    0,    "F",       66,   3,   1); // 16 imem fault
    add_vec(1, 4'hA, 0, 0, 0, 0, 0,  76,   0,    0,    "FDEMMM",  66,   3,   1); // 17 dmem timeout
    add_vec(1, 4'h5, 0, 0, 1, 0, 2,  76,   0,    0,    "FDEMM",   66,   3,   1); // 18 err beats ready
    add_vec(1, 4'hA, 0, 0, 0, 0, 0,  76,   0,    0,    "FDEM",    66,   1,   0); // 19 reset mid-MEMORY

    #1;
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].pre_reset) do_reset();
      run_vec(i);
    end

    do_reset();
    mc = 0;
    for (int k = 0; k < vecs[19].seq.len(); k++) step(19, vecs[19].seq[k], mc);
    chk("mid_mem_en", {63'd0, mem_en_o}, 64'd1);
    do_reset();
    run_vec(0);

    @(negedge clk_i); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
